// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencer in front of an 8-bit combinational alu.
// Owns the accumulator and accepts one instruction per valid/ready handshake.
// It drives the alu inputs and holds them for SETTLE cycles.
// It then writes alu_out back into the accumulator and pulses done.
module alu_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] alu_accum,
    output logic [WIDTH-1:0] alu_data,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] acc,
    output logic             zero,
    output logic             done,
    output logic             busy
);

    // Settle counter only needs to hold SETTLE-1; keep at least one bit.
    localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE - 1);
    localparam logic [2:0]     OP_ACC   = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic             r_zero;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_opcode;
    logic             r_done;
    logic             w_accept;

    assign w_accept = in_valid & in_ready;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> EXEC on handshake, EXEC for SETTLE cycles, then one WB cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_EXEC;
            S_EXEC:  if (r_cnt == '0) w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs depend on state only (plus reset), never on in_valid.
    always_comb begin
        in_ready = (r_state == S_IDLE) & ~rst;
        busy     = (r_state != S_IDLE);
    end

    // Datapath: latch the instruction on accept, count the settle time, write back in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_zero   <= 1'b1;
            r_data   <= '0;
            r_opcode <= OP_ACC;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opcode <= in_op;
                        r_data   <= in_data;
                        r_cnt    <= CNT_INIT;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_WB: begin
                    // zero is computed from the same value written to acc, so it is never stale.
                    r_acc  <= alu_out;
                    r_zero <= (alu_out == '0);
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign acc        = r_acc;
    assign alu_accum  = r_acc;
    assign zero       = r_zero;
    assign alu_data   = r_data;
    assign alu_opcode = r_opcode;
    assign done       = r_done;

endmodule

// File: tb/tb_alu_ctrl.sv
// Testbench for alu_ctrl. Two instances are built: one with SETTLE=1 and one with SETTLE=3.
// A behavioural alu is attached to each instance.
// The driver pushes the expected accumulator and done time into a queue on every accept.
// A separate monitor pops and compares the queue whenever done is seen.
module tb_alu_ctrl;

    localparam int ST[2] = '{1, 3};

    typedef struct {
        logic [7:0] acc;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic       rst       [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [2:0] in_op     [2];
    logic [7:0] in_data   [2];
    logic [7:0] alu_accum [2];
    logic [7:0] alu_data  [2];
    logic [2:0] alu_opcode[2];
    logic [7:0] alu_out   [2];
    logic [7:0] acc       [2];
    logic       zero      [2];
    logic       done      [2];
    logic       busy      [2];

    exp_t q0[$];
    exp_t q1[$];
    int   model_acc[2];

    // Combinational alu seen by the controller.
    function automatic logic [7:0] env_alu(logic [2:0] op, logic [7:0] a, logic [7:0] d);
        case (op)
            3'b000:  return a & d;
            3'b001:  return a | d;
            3'b010:  return ~a;
            3'b011:  return a ^ d;
            3'b100:  return a + d;
            3'b101:  return a - d;
            3'b110:  return a;
            default: return d;
        endcase
    endfunction

    assign alu_out[0] = env_alu(alu_opcode[0], alu_accum[0], alu_data[0]);
    assign alu_out[1] = env_alu(alu_opcode[1], alu_accum[1], alu_data[1]);

    alu_ctrl #(.WIDTH(8), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_op(in_op[0]), .in_data(in_data[0]), .alu_accum(alu_accum[0]),
        .alu_data(alu_data[0]), .alu_opcode(alu_opcode[0]), .alu_out(alu_out[0]),
        .acc(acc[0]), .zero(zero[0]), .done(done[0]), .busy(busy[0])
    );

    alu_ctrl #(.WIDTH(8), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_op(in_op[1]), .in_data(in_data[1]), .alu_accum(alu_accum[1]),
        .alu_data(alu_data[1]), .alu_opcode(alu_opcode[1]), .alu_out(alu_out[1]),
        .acc(acc[1]), .zero(zero[1]), .done(done[1]), .busy(busy[1])
    );

    // Reference: the next accumulator value computed with plain integer arithmetic.
    function automatic int ref_next(int op, int a, int d);
        case (op)
            0:       return a & d;
            1:       return a | d;
            2:       return 255 - a;
            3:       return a ^ d;
            4:       return (a + d) % 256;
            5:       return (a - d + 256) % 256;
            6:       return a;
            default: return d;
        endcase
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void push_exp(int k, exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void pop_exp(input int k, output exp_t e, output bit ok);
        ok    = 1'b0;
        e.acc = '0;
        e.cyc = 0;
        if (k == 0 && q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (k == 1 && q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        for (int k = 0; k < 2; k++) begin
            if (done[k] === 1'b1) begin
                pop_exp(k, e, ok);
                if (!ok) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    $display("[TB] dut%0d writeback acc=%02h zero=%0b cyc=%0d", k, acc[k], zero[k], cyc);
                    check("wb_acc", {24'd0, acc[k]}, {24'd0, e.acc});
                    check("wb_zero", {31'd0, zero[k]}, {31'd0, (e.acc == 8'h00)});
                    check("wb_latency", cyc, e.cyc);
                end
            end
        end
    end

    // Issue one instruction to instance k; must be called just after a falling edge.
    // With hold set, in_valid stays high with random garbage while the instruction is in flight.
    task automatic issue(input int k, input logic [2:0] op, input logic [7:0] d, input bit hold);
        int   w;
        exp_t e;
        w = 0;
        in_valid[k] = 1'b1;
        in_op[k]    = op;
        in_data[k]  = d;
        while (in_ready[k] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (in_ready[k] !== 1'b1) begin
            check("accept_timeout", 32'd1, 32'd0);
            in_valid[k] = 1'b0;
            return;
        end
        model_acc[k] = ref_next(int'(op), model_acc[k], int'(d));
        e.acc = 8'(model_acc[k]);
        e.cyc = cyc + 1 + ST[k] + 1;
        push_exp(k, e);
        $display("[TB] dut%0d accept op=%0d data=%02h expect acc=%02h", k, op, d, e.acc);
        @(posedge clk);
        #1;
        if (hold) begin
            w = 0;
            do begin
                in_op[k]   = 3'($urandom);
                in_data[k] = 8'($urandom);
                @(negedge clk);
                w++;
            end while (busy[k] === 1'b1 && w < 50);
            in_valid[k] = 1'b0;
        end else begin
            in_valid[k] = 1'b0;
            @(negedge clk);
        end
    endtask

    // Wait until instance k has retired everything, then compare its visible state with the model.
    task automatic drain(input int k);
        int t;
        t = 0;
        while ((qsize(k) != 0 || busy[k] !== 1'b0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", {31'd0, (t >= 100)}, 32'd0);
        check("acc_state", {24'd0, acc[k]}, 32'(model_acc[k]));
        check("zero_state", {31'd0, zero[k]}, {31'd0, (model_acc[k] == 0)});
        check("alu_accum", {24'd0, alu_accum[k]}, 32'(model_acc[k]));
        check("ready_idle", {31'd0, in_ready[k]}, 32'd1);
    endtask

    // Reset instance k while its current instruction is still in EXEC.
    task automatic reset_mid(input int k);
        issue(k, 3'b111, 8'h55, 1'b0);
        rst[k] = 1'b1;
        if (k == 0) q0.delete();
        else        q1.delete();
        model_acc[k] = 0;
        @(negedge clk);
        check("rst_ready_low", {31'd0, in_ready[k]}, 32'd0);
        rst[k] = 1'b0;
        #1;
        check("rst_acc", {24'd0, acc[k]}, 32'd0);
        check("rst_zero", {31'd0, zero[k]}, 32'd1);
        check("rst_done", {31'd0, done[k]}, 32'd0);
        check("rst_busy", {31'd0, busy[k]}, 32'd0);
        check("rst_ready", {31'd0, in_ready[k]}, 32'd1);
        repeat (6) @(negedge clk);
        check("rst_acc_hold", {24'd0, acc[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]       = 1'b1;
            in_valid[k]  = 1'b0;
            in_op[k]     = 3'b000;
            in_data[k]   = 8'h00;
            model_acc[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_ready_in_rst", {31'd0, in_ready[k]}, 32'd0);
            rst[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_acc", {24'd0, acc[k]}, 32'd0);
            check("reset_zero", {31'd0, zero[k]}, 32'd1);
            check("reset_ready", {31'd0, in_ready[k]}, 32'd1);
            check("reset_busy", {31'd0, busy[k]}, 32'd0);
            check("reset_done", {31'd0, done[k]}, 32'd0);
            check("reset_opcode", {29'd0, alu_opcode[k]}, 32'd6);
            check("reset_data", {24'd0, alu_data[k]}, 32'd0);
        end
        @(negedge clk);

        // Directed sequences on the SETTLE=1 instance.
        issue(0, 3'b111, 8'h0F, 1'b0);
        drain(0);
        check("dat_0f", {24'd0, acc[0]}, 32'h0F);
        issue(0, 3'b001, 8'hF0, 1'b0);
        drain(0);
        check("or_ff", {24'd0, acc[0]}, 32'hFF);
        issue(0, 3'b111, 8'h0F, 1'b0);
        issue(0, 3'b000, 8'hF0, 1'b0);
        drain(0);
        check("and_zero", {31'd0, zero[0]}, 32'd1);
        issue(0, 3'b111, 8'h0F, 1'b0);
        issue(0, 3'b011, 8'hF0, 1'b0);
        drain(0);
        check("xor_ff", {24'd0, acc[0]}, 32'hFF);
        issue(0, 3'b010, 8'h00, 1'b0);
        drain(0);
        check("not_00", {24'd0, acc[0]}, 32'h00);
        issue(0, 3'b111, 8'hFF, 1'b0);
        issue(0, 3'b100, 8'h01, 1'b0);
        drain(0);
        check("add_wrap", {24'd0, acc[0]}, 32'h00);
        issue(0, 3'b101, 8'h01, 1'b0);
        drain(0);
        check("sub_wrap", {24'd0, acc[0]}, 32'hFF);

        // in_valid held high with changing ops while busy: only the first op executes.
        issue(0, 3'b111, 8'h3C, 1'b1);
        drain(0);
        check("hold_first_only", {24'd0, acc[0]}, 32'h3C);
        issue(1, 3'b111, 8'hA5, 1'b1);
        drain(1);
        check("hold_first_only_s3", {24'd0, acc[1]}, 32'hA5);

        // Random traffic on both instances.
        for (int i = 0; i < 30; i++) begin
            issue(0, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain(0);
        for (int i = 0; i < 20; i++) begin
            issue(1, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain(1);

        // Reset during EXEC aborts the instruction.
        reset_mid(0);
        reset_mid(1);

        repeat (4) @(negedge clk);
        check("queue0_empty", 32'(q0.size()), 32'd0);
        check("queue1_empty", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
